// File: rtl/alu_vector_gen.sv
// Exhaustive stimulus generator for an N-bit add/sub unit: sweeps {a, b, op} with a golden result.
// Optional result checker enabled by defining ALU_VEC_GEN_CHECK_EN.
module alu_vector_gen #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      vec_ready,
    output logic                      vec_valid,
    output logic [DATA_WIDTH-1:0]     vec_a,
    output logic [DATA_WIDTH-1:0]     vec_b,
    output logic                      vec_op,
    output logic [DATA_WIDTH:0]       vec_golden,
    output logic [2*DATA_WIDTH:0]     vec_index,
`ifdef ALU_VEC_GEN_CHECK_EN
    input  logic [DATA_WIDTH:0]       dut_result,
    output logic [2*DATA_WIDTH+1:0]   mismatch_cnt,
    output logic                      err,
`endif
    output logic                      done
);
    localparam int GOLDEN_WIDTH = DATA_WIDTH + 1;
    localparam int INDEX_WIDTH  = 2 * DATA_WIDTH + 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = {INDEX_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  r_state;
    logic                    r_valid;
    logic                    r_done;
    logic [INDEX_WIDTH-1:0]  r_index;
    logic [GOLDEN_WIDTH-1:0] r_golden;

    logic                    w_accept;
    logic [INDEX_WIDTH-1:0]  w_nextIndex;

    // Golden for a packed index: unsigned add with carry out, or subtract whose MSB is the borrow.
    function automatic logic [GOLDEN_WIDTH-1:0] goldenOf(input logic [INDEX_WIDTH-1:0] idx);
        logic [GOLDEN_WIDTH-1:0] a;
        logic [GOLDEN_WIDTH-1:0] b;
        a = {1'b0, idx[INDEX_WIDTH-1:DATA_WIDTH+1]};
        b = {1'b0, idx[DATA_WIDTH:1]};
        return idx[0] ? (a - b) : (a + b);
    endfunction

    assign w_accept    = r_valid & vec_ready;
    assign w_nextIndex = r_index + 1'b1;

`ifdef ALU_VEC_GEN_CHECK_EN
    logic [INDEX_WIDTH:0] r_mismatchCnt;
    logic                 r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_index  <= '0;
            r_golden <= '0;
`ifdef ALU_VEC_GEN_CHECK_EN
            r_mismatchCnt <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state  <= RUN;
                        r_valid  <= 1'b1;
                        r_done   <= 1'b0;
                        r_index  <= '0;
                        r_golden <= '0;
`ifdef ALU_VEC_GEN_CHECK_EN
                        r_mismatchCnt <= '0;
                        r_err         <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        // The final vector stays on the outputs after the sweep ends.
                        if (r_index == LAST_INDEX) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_index  <= w_nextIndex;
                            r_golden <= goldenOf(w_nextIndex);
                        end
`ifdef ALU_VEC_GEN_CHECK_EN
                        if (dut_result != r_golden) begin
                            r_err <= 1'b1;
                            if (r_mismatchCnt != {(INDEX_WIDTH+1){1'b1}}) begin
                                r_mismatchCnt <= r_mismatchCnt + 1'b1;
                            end
                        end
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign vec_valid  = r_valid;
    assign done       = r_done;
    assign vec_index  = r_index;
    assign vec_a      = r_index[INDEX_WIDTH-1:DATA_WIDTH+1];
    assign vec_b      = r_index[DATA_WIDTH:1];
    assign vec_op     = r_index[0];
    assign vec_golden = r_golden;

`ifdef ALU_VEC_GEN_CHECK_EN
    assign mismatch_cnt = r_mismatchCnt;
    assign err          = r_err;
`endif

endmodule

// File: doc/alu_vector_gen.md
ALU_VECTOR_GEN -- requirements
Module: alu_vector_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 4, operand width N of the add/sub unit under test.
REQ-002 Derived localparams: GOLDEN_WIDTH = DATA_WIDTH+1; INDEX_WIDTH = 2*DATA_WIDTH+1. Neither is overridable.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  level-sampled request to begin a sweep.
REQ-007 vec_ready  input  1  consumer accepts the current vector.
REQ-008 vec_valid  output  1  current vector fields are valid.
REQ-009 vec_a  output  DATA_WIDTH  operand a.
REQ-010 vec_b  output  DATA_WIDTH  operand b.
REQ-011 vec_op  output  1  operation: 0 = add, 1 = subtract.
REQ-012 vec_golden  output  GOLDEN_WIDTH  expected result, MSB = carry/borrow.
REQ-013 vec_index  output  INDEX_WIDTH  sweep position, equal to {vec_a, vec_b, vec_op}.
REQ-014 done  output  1  sweep complete.
REQ-015 Check ports, present only with ALU_VEC_GEN_CHECK_EN: dut_result input GOLDEN_WIDTH; mismatch_cnt output INDEX_WIDTH+1; err output 1.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE: on start=1, go to RUN and load index 0. vec_valid rises on the next cycle with a=0, b=0, op=0.
REQ-018 RUN: vec_valid=1; an accept is vec_valid & vec_ready at a rising edge.
REQ-019 On an accept below the last index, increment the index. The next vector is valid the following cycle, giving one vector per cycle with no bubbles.
REQ-020 Without an accept, all vec_* outputs hold stable and vec_valid stays 1; vec_valid never drops in RUN.
REQ-021 On an accept of index 2^INDEX_WIDTH-1 (511 for N=4), go to DONE. The index does not wrap.
REQ-022 DONE: vec_valid=0, done=1, and vec fields hold the last vector. start=1 restarts at RUN with index 0, clears done, and clears the check state.
REQ-023 start is ignored in RUN.
REQ-024 Field mapping: vec_a = index[INDEX_WIDTH-1:DATA_WIDTH+1], vec_b = index[DATA_WIDTH:1], vec_op = index[0].
REQ-025 Golden for op=0: {1'b0,a} + {1'b0,b}, GOLDEN_WIDTH bits, carry in the MSB.
REQ-026 Golden for op=1: ({1'b0,a} - {1'b0,b}) mod 2^GOLDEN_WIDTH, MSB = 1 iff a<b.
REQ-027 vec_golden is registered and always consistent with the vec_a/vec_b/vec_op of the same cycle.

Reset
REQ-028 rst=1 at an edge forces IDLE in any state, including mid-sweep or with vec_valid high and vec_ready low.
REQ-029 Reset values: vec_valid=0, done=0, vec_a=0, vec_b=0, vec_op=0, vec_golden=0, vec_index=0, mismatch_cnt=0, err=0.
REQ-030 rst has priority over start and vec_ready in the same cycle.

Configuration
REQ-031 Macro ALU_VEC_GEN_CHECK_EN defined: the check ports exist.
REQ-032 With the macro, on each accept compare dut_result against vec_golden (DUT combinational from vec_a/vec_b/vec_op).
REQ-033 On inequality, mismatch_cnt increments (saturating at all-ones) and err sets sticky until rst or restart.
REQ-034 Macro undefined: the check ports and logic are absent and all other behaviour is identical.

Verification
REQ-035 rst=1 for 2 cycles from any state -> all outputs 0 and FSM in IDLE next cycle.
REQ-036 start pulse, vec_ready=1 held -> index 0..511 on 512 consecutive cycles starting the cycle after start; done=1 and vec_valid=0 the cycle after the index-511 accept.
REQ-037 Golden spot checks, N=4:
  - index 0x1E3 (a=F, b=1, op=1) -> golden 0x0E.
  - index 0x1FE (a=F, b=F, op=0) -> golden 0x1E.
  - index 0x003 (a=0, b=1, op=1) -> golden 0x1F.
REQ-038 vec_ready=0 for 3 cycles while index=5 -> vec_valid=1 and all fields frozen at index 5; index 6 appears the cycle after vec_ready returns to 1.
REQ-039 rst=1 at index 100 with vec_ready=0 -> IDLE next cycle; a later start restarts at index 0.
REQ-040 With ALU_VEC_GEN_CHECK_EN, dut_result = golden XOR 1 only at index 7, else correct -> after the sweep mismatch_cnt=1 and err=1; a restart clears both.
